// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive deframer.
// The optional UART_RX_BREAK_DETECT_EN build adds the BREAK_WAIT state.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int MID_BIT = OVERSAMPLE_DEFAULT / 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        RX_BREAK_WAIT
`endif
    } rx_state_e;

    function automatic int mid_bit(input int os);
        return os / 2;
    endfunction

    function automatic logic parity_calc(
        input logic [8:0] data,
        input logic       odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start validation, mid-bit sampling, handshake, status.
// Define UART_RX_BREAK_DETECT_EN to enable break detection (break_det, BREAK_WAIT).
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_16x,
    input  logic                 rx_filtered,
    input  logic                 falling_edge,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy,
    output logic                 break_det
);

    localparam int MID = mid_bit(OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_e state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 par_err_q, par_err_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 done;
    logic [8:0]           data_ext;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 par_bit_q, par_bit_d;
    logic                 brk_q, brk_d;
`endif

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        par_err_d    = par_err_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        done         = 1'b0;
        data_ext     = '0;
        data_ext[DATA_BITS-1:0] = shift_q;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d    = par_bit_q;
        brk_d        = 1'b0;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            RX_IDLE: begin
                if (falling_edge) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_en_d   = parity_en;
                    par_odd_d  = parity_odd;
                    par_err_d  = 1'b0;
                end
            end
            RX_START: begin
                if (tick_16x) begin
                    if (tick_cnt_q == TW'(MID - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = rx_filtered ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick_16x) begin
                    if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_filtered, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (tick_16x) begin
                    if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        par_err_d  = rx_filtered != parity_calc(data_ext, par_odd_q);
`ifdef UART_RX_BREAK_DETECT_EN
                        par_bit_d  = rx_filtered;
`endif
                        state_d    = RX_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (tick_16x) begin
                    if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = RX_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                        // All-zero frame including stop: line held in break
                        if (!rx_filtered && shift_q == '0 &&
                            !(par_en_q && par_bit_q)) begin
                            brk_d       = 1'b1;
                            frame_err_d = 1'b1;
                            state_d     = RX_BREAK_WAIT;
                        end else begin
                            done = 1'b1;
                        end
`else
                        done = 1'b1;
`endif
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            RX_BREAK_WAIT: begin
                if (tick_16x && rx_filtered) begin
                    state_d = RX_IDLE;
                end
            end
`endif
            default: state_d = RX_IDLE;
        endcase

        if (done) begin
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            frame_err_d  = !rx_filtered;
            parity_err_d = par_err_q;
            overrun_d    = rx_valid_q && !rx_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            par_err_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q    <= 1'b0;
            brk_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            par_err_q    <= par_err_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q    <= par_bit_d;
            brk_q        <= brk_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;
    assign rx_busy     = state_q != RX_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det   = brk_q;
`else
    assign break_det   = 1'b0;
`endif

endmodule
